// File: rtl/piso_tx_8b.sv
// Parallel-in serial-out frame transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit, each held CLKS_PER_BIT clocks.
module piso_tx_8b #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       ser_out_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned     CntW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] CntReload = CntW'(CLKS_PER_BIT - 1);
  localparam logic            ParEn     = (PARITY_EN != 0);
  localparam logic            ParOdd    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx_q;
  logic            par_q;
  logic            ser_q;
  logic            done_q;

  logic bit_end;
  logic accept;
  logic enter_stop;
  logic done_d;

  always_comb begin
    bit_end    = (cnt_q == '0);
    accept     = tx_valid_i && tx_ready_o;
    enter_stop = bit_end && ((state_q == StData && bit_idx_q == 3'd7 && !ParEn) ||
                             state_q == StParity);
    // done marks the final clock of the stop bit; with one-clock bits that is
    // the clock right after entering STOP.
    if (CLKS_PER_BIT == 1) begin
      done_d = enter_stop;
    end else begin
      done_d = (state_q == StStop) && (cnt_q == CntW'(1));
    end
  end

  // Ready also during the last stop clock so a held word starts with no gap.
  assign tx_ready_o = (state_q == StIdle) || done_q;
  assign busy_o     = (state_q != StIdle);
  assign ser_out_o  = ser_q;
  assign done_o     = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      ser_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        shift_q <= tx_data_i;
        par_q   <= (^tx_data_i) ^ ParOdd;
        state_q <= StStart;
        ser_q   <= 1'b0;
        cnt_q   <= CntReload;
      end else begin
        unique case (state_q)
          StIdle: begin
            ser_q <= 1'b1;
          end
          StStart: begin
            if (bit_end) begin
              state_q <= StData;
              ser_q   <= shift_q[0];
              cnt_q   <= CntReload;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StData: begin
            if (bit_end) begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              cnt_q     <= CntReload;
              if (bit_idx_q == 3'd7) begin
                if (ParEn) begin
                  state_q <= StParity;
                  ser_q   <= par_q;
                end else begin
                  state_q <= StStop;
                  ser_q   <= 1'b1;
                end
              end else begin
                ser_q <= shift_q[1];
              end
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StParity: begin
            if (bit_end) begin
              state_q <= StStop;
              ser_q   <= 1'b1;
              cnt_q   <= CntReload;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StStop: begin
            if (bit_end) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            ser_q   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
